// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - frame capture sequencer: arms on start, streams N frames of pixels to a sink
module capture_sequencer #(
    parameter int          HTOTAL   = 800,
    parameter int          VTOTAL   = 525,
    parameter bit          HSYNCPOL = 1'b0,
    parameter bit          VSYNCPOL = 1'b0,
    parameter logic [7:0]  SYNCGREY = 8'h40,
    parameter int          NFW      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [NFW-1:0]  nframes,
    input  logic [10:0]     hc,
    input  logic [10:0]     vc,
    input  logic [7:0]      r,
    input  logic [7:0]      g,
    input  logic [7:0]      b,
    input  logic            hsync,
    input  logic            vsync,
    output logic [23:0]     pix_data,
    output logic            pix_valid,
    input  logic            pix_ready,
    output logic            pix_eof,
    output logic [NFW-1:0]  frame_cnt,
    output logic            busy,
    output logic            done,
    output logic            overrun
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPT, S_DONE} state_t;

    localparam logic [10:0] HLAST = 11'(HTOTAL - 1);
    localparam logic [10:0] VLAST = 11'(VTOTAL - 1);

    state_t         state_q, state_d;
    logic [NFW-1:0] nframes_q, nframes_d;
    logic [NFW-1:0] frame_cnt_q, frame_cnt_d;
    logic           overrun_q, overrun_d;
    logic           pix_valid_q, pix_valid_d;
    logic           pix_eof_q, pix_eof_d;
    logic [23:0]    pix_data_q, pix_data_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           eof_pos;
    logic           insync;
    logic [NFW-1:0] cnt_inc;

    assign eof_pos = (hc == HLAST) && (vc == VLAST);
    assign insync  = (hsync == HSYNCPOL) || (vsync == VSYNCPOL);
    assign cnt_inc = frame_cnt_q + NFW'(1);

    always_comb begin
        state_d     = state_q;
        nframes_d   = nframes_q;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q;
        pix_valid_d = pix_valid_q;
        pix_eof_d   = pix_eof_q;
        pix_data_d  = pix_data_q;

        case (state_q)
            S_IDLE: begin
                if (start && (nframes != '0)) begin
                    state_d     = S_ARM;
                    nframes_d   = nframes;
                    frame_cnt_d = '0;
                    overrun_d   = 1'b0;
                end
            end
            S_ARM: begin
                if (eof_pos) state_d = S_CAPT;
            end
            S_CAPT: begin
                if (eof_pos) begin
                    frame_cnt_d = cnt_inc;
                    if (cnt_inc == nframes_q) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Single-entry output register: a stalled sink keeps the held pixel, new ones are lost.
        if (pix_valid_q && pix_ready) begin
            pix_valid_d = 1'b0;
            pix_eof_d   = 1'b0;
        end
        if (state_q == S_CAPT) begin
            if (!pix_valid_q || pix_ready) begin
                pix_valid_d = 1'b1;
                pix_eof_d   = eof_pos;
                pix_data_d  = insync ? {3{SYNCGREY}} : {r, g, b};
            end else begin
                overrun_d = 1'b1;
            end
        end

        // Abort wins over everything, but leaves the counters readable.
        if (abort) begin
            state_d     = S_IDLE;
            nframes_d   = nframes_q;
            frame_cnt_d = frame_cnt_q;
            overrun_d   = overrun_q;
            pix_valid_d = 1'b0;
            pix_eof_d   = 1'b0;
        end

        busy_d = (state_d == S_ARM) || (state_d == S_CAPT);
        done_d = (state_q == S_DONE) && !abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            nframes_q   <= '0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_eof_q   <= 1'b0;
            pix_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            nframes_q   <= nframes_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
            pix_valid_q <= pix_valid_d;
            pix_eof_q   <= pix_eof_d;
            pix_data_q  <= pix_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign pix_eof   = pix_eof_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - table-driven bench for capture_sequencer on a reduced 8x4 frame
module tb_capture_sequencer;

    localparam int HT   = 8;
    localparam int VT   = 4;
    localparam int NPIX = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  nframes = 8'd0;
    logic [10:0] hc = '0;
    logic [10:0] vc = '0;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic        hsync = 1'b1, vsync = 1'b1;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        pix_eof;
    logic [7:0]  frame_cnt;
    logic        busy, done, overrun;

    always #5 clk = ~clk;

    capture_sequencer #(
        .HTOTAL(HT), .VTOTAL(VT), .HSYNCPOL(1'b0), .VSYNCPOL(1'b0),
        .SYNCGREY(8'h40), .NFW(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .nframes(nframes),
        .hc(hc), .vc(vc), .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_eof(pix_eof),
        .frame_cnt(frame_cnt), .busy(busy), .done(done), .overrun(overrun)
    );

    typedef struct {
        logic [7:0] nf;
        bit         stall;
        bit         abrt;
        bit         restart;
        int         exp_beats;
        logic [7:0] exp_cnt;
        bit         exp_ovr;
        int         exp_dones;
    } row_t;

    row_t rows[6];

    int checks = 0, errors = 0;
    int h = 0, v = 0, idx = 0, beats = 0, dones = 0, cyc = 0;
    int eof_cyc = -10, done_cyc = -10;

    // Hsync active at h==6, vsync active on line 3; column 5 carries full white.
    function automatic logic [23:0] exp_pix(int i);
        int ph = i % HT;
        int pv = i / HT;
        if (ph == 6 || pv == 3) return 24'h404040;
        if (ph == 5) return 24'hFFFFFF;
        return {4'(ph), 4'(pv), 16'hC33C};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        hc    = 11'(h);
        vc    = 11'(v);
        hsync = (h == 6) ? 1'b0 : 1'b1;
        vsync = (v == 3) ? 1'b0 : 1'b1;
        {r, g, b} = (h == 5) ? 24'hFFFFFF : {4'(h), 4'(v), 16'hC33C};
        if (pix_valid && pix_ready) begin
            check("beat_data", pix_data, exp_pix(idx));
            check("beat_eof", pix_eof, idx == NPIX - 1);
            if (pix_eof) eof_cyc = cyc;
            idx = (idx + 1) % NPIX;
            beats++;
        end
        if (done) begin
            dones++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        h = h + 1;
        if (h == HT) begin
            h = 0;
            v = (v + 1) % VT;
        end
        cyc++;
    endtask

    task automatic align();
        for (int k = 0; k < 2 * NPIX && !(h == 3 && v == 1); k++) tick();
    endtask

    initial begin
        rows[0] = '{nf: 8'd1,   stall: 0, abrt: 0, restart: 0, exp_beats: NPIX,       exp_cnt: 8'd1,   exp_ovr: 0, exp_dones: 1};
        rows[1] = '{nf: 8'd3,   stall: 0, abrt: 0, restart: 1, exp_beats: 3 * NPIX,   exp_cnt: 8'd3,   exp_ovr: 0, exp_dones: 1};
        rows[2] = '{nf: 8'd1,   stall: 1, abrt: 0, restart: 0, exp_beats: NPIX - 5,   exp_cnt: 8'd1,   exp_ovr: 1, exp_dones: 1};
        rows[3] = '{nf: 8'd2,   stall: 0, abrt: 1, restart: 0, exp_beats: -1,         exp_cnt: 8'd1,   exp_ovr: 0, exp_dones: 0};
        rows[4] = '{nf: 8'd0,   stall: 0, abrt: 0, restart: 0, exp_beats: 0,          exp_cnt: 8'd1,   exp_ovr: 0, exp_dones: 0};
        rows[5] = '{nf: 8'd255, stall: 0, abrt: 0, restart: 0, exp_beats: 255 * NPIX, exp_cnt: 8'd255, exp_ovr: 0, exp_dones: 1};

        tick();
        tick();
        check("rst_valid", pix_valid, 0);
        check("rst_data", pix_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", frame_cnt, 0);
        check("rst_ovr", overrun, 0);
        rst_n = 1'b1;

        for (int ri = 0; ri < 6; ri++) begin
            int budget;
            int stall_done;
            bit skipped, aborted, restarted;
            budget = NPIX * (int'(rows[ri].nf) + 2) + 20;
            stall_done = 0;
            skipped = 0;
            aborted = 0;
            restarted = 0;
            align();
            beats = 0; dones = 0; idx = 0; eof_cyc = -10; done_cyc = -10;
            nframes = rows[ri].nf;
            start = 1'b1;
            tick();
            start = 1'b0;
            check("busy_after_start", busy, rows[ri].nf != 0);
            for (int n = 0; n < budget; n++) begin
                pix_ready = 1'b1;
                if (rows[ri].stall && beats >= 10 && stall_done < 5) begin
                    pix_ready = 1'b0;
                    check("stall_valid", pix_valid, 1);
                    if (stall_done > 0) check("stall_hold", pix_data, exp_pix(idx));
                    stall_done++;
                end
                if (rows[ri].restart && beats == 40 && !restarted) begin
                    restarted = 1;
                    start = 1'b1;
                    nframes = 8'd1;
                end
                if (rows[ri].abrt && beats >= NPIX + 10 && !aborted) begin
                    aborted = 1;
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    check("abort_valid", pix_valid, 0);
                    check("abort_busy", busy, 0);
                    check("abort_cnt", frame_cnt, 1);
                end else begin
                    tick();
                end
                start = 1'b0;
                if (stall_done == 5 && pix_ready && !skipped) begin
                    skipped = 1;
                    idx = (idx + 5) % NPIX;
                end
                if (dones > 0 && cyc > done_cyc + 2) break;
            end
            pix_ready = 1'b1;
            check("frame_cnt", frame_cnt, rows[ri].exp_cnt);
            check("overrun", overrun, rows[ri].exp_ovr);
            check("done_pulses", dones, rows[ri].exp_dones);
            check("busy_end", busy, 0);
            if (rows[ri].exp_beats >= 0) check("beats", beats, rows[ri].exp_beats);
            if (rows[ri].exp_dones > 0) check("done_after_eof", done_cyc, eof_cyc + 1);
        end

        align();
        idx = 0;
        beats = 0;
        nframes = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 3 * NPIX && beats < 5; n++) tick();
        check("pre_rst_valid", pix_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", pix_valid, 0);
        check("mid_rst_data", pix_data, 0);
        check("mid_rst_eof", pix_eof, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cnt", frame_cnt, 0);
        check("mid_rst_ovr", overrun, 0);
        dones = 0;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 2 * NPIX; n++) tick();
        check("post_rst_done", dones, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", pix_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
